// File: rtl/fifo_wr_arbiter.sv
// Two-producer round-robin write controller for a shared 2^ADDR_WIDTH-deep FIFO RAM.
// Define FIFO_WR_ARB_ALMOST_FULL_EN to add almost_full and near-full fixed priority for producer 0.
module fifo_wr_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  rd_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   WriteAddr,
  output logic [ADDR_WIDTH:0]   ReadAddr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic                  grant_id,
  output logic                  rd_err
);

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                last_q, last_d;
  logic                gid_q, gid_d;
  logic                rd_err_q, rd_err_d;

  logic empty_w, full_w;
  logic gnt0, gnt1, pick1;
  logic wr_acc, rd_acc;

  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  assign WriteAddr = wptr_q;
  assign ReadAddr  = rptr_q;
  assign count     = wptr_q - rptr_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign mem_raddr = rptr_q[ADDR_WIDTH-1:0];
  assign grant_id  = gid_q;
  assign rd_err    = rd_err_q;

`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_T    = (ADDR_WIDTH+1)'(AF_THRESH);
  logic [ADDR_WIDTH:0] free_w;
  logic                af_w;
  assign free_w      = DEPTH_V - count;
  assign af_w        = rst_n && (free_w <= AF_T);
  assign almost_full = af_w;
`endif

  // Contested cycles favour whoever did not win last; ready never feeds back on itself.
  always_comb begin
    pick1 = ~last_q;
`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
    if (af_w) pick1 = 1'b0;
`endif
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !full_w) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~pick1;
        gnt1 = pick1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wr_acc     = gnt0 | gnt1;
  assign rd_acc     = rd_en & ~empty_w;

  assign mem_we    = wr_acc;
  assign mem_waddr = wptr_q[ADDR_WIDTH-1:0];
  assign mem_wdata = gnt1 ? req1_data : req0_data;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    last_d   = last_q;
    gid_d    = gid_q;
    rd_err_d = rd_en & empty_w;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
      last_d = gnt1;
      gid_d  = gnt1;
    end
    if (rd_acc) rptr_d = rptr_q + 1'b1;
  end

  // last_q resets to 1 so producer 0 takes the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
